// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: select encodings, NOP and opcodes.
// Imported by the fetch stage, its PC generator and the decode stage.
package pipe_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Instruction select presented to decode
    typedef enum logic [1:0] {
        HZ_NORMAL = 2'b00,
        HZ_FLUSH  = 2'b01,
        HZ_REPLAY = 2'b10
    } hz_reg_e;

    // Control-kill reason presented to decode
    typedef enum logic [1:0] {
        HC_NONE     = 2'b00,
        HC_REDIRECT = 2'b01,
        HC_STALL    = 2'b10
    } hz_ctrl_e;

    // Next-PC source
    typedef enum logic [1:0] {
        PC_SEQ   = 2'b00,
        PC_HOLD  = 2'b01,
        PC_REDIR = 2'b10
    } pc_sel_e;

    // RV32I major opcodes
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Instructions are word aligned; low address bits are dropped
    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_pc_gen.sv
// PC register with next-PC mux (sequential / hold / redirect) and the
// one-cycle delayed copy that tags the instruction currently in decode.
// Ports: clk, rst (async high), pc_sel, target -> pc, pc_dly.
module if_pc_gen
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  pc_sel_e     pc_sel,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_dly
);

    logic [31:0] pc_next;
    logic [31:0] dly_next;

    always_comb begin
        pc_next  = pc + 32'd4;
        dly_next = pc;
        unique case (pc_sel)
            PC_REDIR: pc_next = align_pc(target);
            PC_HOLD: begin
                pc_next  = pc;
                dly_next = pc_dly;
            end
            default: pc_next = pc + 32'd4;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            pc_dly <= RESET_PC;
        end else begin
            pc     <= pc_next;
            pc_dly <= dly_next;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, memory address, stall buffer and decode selects.
// Ports: clk, rst, stall, redirect(+target), IM_data_in -> im_addr, im_en,
// pc_from_IF, IM_data_buf, hazard_reg, hazard_ctrl.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic [31:0] IM_data_in,
    output logic [31:0] im_addr,
    output logic        im_en,
    output logic [31:0] pc_from_IF,
    output logic [31:0] IM_data_buf,
    output logic [1:0]  hazard_reg,
    output logic [1:0]  hazard_ctrl
);

    import pipe_pkg::*;

    logic     flush_pend;
    logic     stall_q;
    logic     stall_eff;
    pc_sel_e  pc_sel;
    hz_reg_e  sel;
    hz_ctrl_e ctrl;
    logic [31:0] pc;

    // A redirect overrides any stall in the same cycle
    assign stall_eff = stall & ~redirect;

    always_comb begin
        pc_sel = PC_SEQ;
        if (redirect)
            pc_sel = PC_REDIR;
        else if (stall)
            pc_sel = PC_HOLD;
    end

    // Memory data is invalid the cycle after reset or redirect
    always_comb begin
        sel = HZ_NORMAL;
        if (redirect || flush_pend)
            sel = HZ_FLUSH;
        else if (stall_q)
            sel = HZ_REPLAY;
    end

    always_comb begin
        ctrl = HC_NONE;
        if (rst)
            ctrl = HC_NONE;
        else if (redirect)
            ctrl = HC_REDIRECT;
        else if (stall)
            ctrl = HC_STALL;
    end

    if_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk    (clk),
        .rst    (rst),
        .pc_sel (pc_sel),
        .target (redirect_target),
        .pc     (pc),
        .pc_dly (pc_from_IF)
    );

    // Buffer captures what decode sees in the first stall cycle;
    // later stall cycles see HZ_REPLAY and keep it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            IM_data_buf <= NOP_INSTR;
        end else if (stall_eff) begin
            unique case (sel)
                HZ_NORMAL: IM_data_buf <= IM_data_in;
                HZ_FLUSH:  IM_data_buf <= NOP_INSTR;
                default:   IM_data_buf <= IM_data_buf;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_pend <= 1'b1;
            stall_q    <= 1'b0;
        end else begin
            flush_pend <= redirect;
            stall_q    <= stall_eff;
        end
    end

    assign im_addr     = pc;
    assign im_en       = ~rst;
    assign hazard_reg  = sel;
    assign hazard_ctrl = ctrl;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the decode stage.
- Owns the PC register and drives the synchronous instruction-memory address.
- Supplies the decode stage with: the PC of the instruction currently on IM_data_in, a held-instruction buffer for stalls, and the hazard_reg / hazard_ctrl selects it uses to pass, flush or replay an instruction.
- Applies branch/jump redirects from EX and load-use stalls from the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, addi x0,x0,0; written into the buffer when stalling on a flushed slot.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  load-use stall request from the hazard unit.
- redirect  input  1  branch taken or jump resolved in EX.
- redirect_target  input  32  new PC from EX.
- IM_data_in  input  32  instruction memory read data, one cycle after im_addr.
- im_addr  output  32  instruction memory address; equals pc_reg.
- im_en  output  1  instruction memory read enable.
- pc_from_IF  output  32  PC of the instruction presented to decode this cycle.
- IM_data_buf  output  32  held instruction for replay.
- hazard_reg  output  2  decode instruction select: 00 = IM_data_in, 01 = flush (NOP), 10 = IM_data_buf.
- hazard_ctrl  output  2  decode control kill: 00 = none, 01 = redirect, 10 = stall.

Behaviour:
- Reset (async, immediate):
  - pc_reg = RESET_PC, pc_from_IF = RESET_PC.
  - IM_data_buf = NOP_INSTR.
  - flush_pend = 1; hazard_reg = 01 while held and through the first cycle after release, because memory data is not yet valid.
  - stall_q = 0, im_en = 0, hazard_ctrl = 00.
  - Reset mid-operation discards all in-flight state.
- im_en: 1 in every cycle out of reset.
- Memory latency: address issued at cycle t, data on IM_data_in at t+1. pc_from_IF is pc_reg delayed one cycle, so it is always aligned with the decoded instruction.
- Priority: redirect > stall > normal.
- Normal (no stall, no redirect):
  - pc_reg <= pc_reg + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
  - pc_from_IF <= pc_reg.
- Redirect at cycle t:
  - pc_reg <= {redirect_target[31:2], 2'b00}; misaligned bits are silently dropped.
  - hazard_reg = 01 and hazard_ctrl = 01 combinationally in cycle t. This kills the wrong-path instruction in decode.
  - flush_pend <= 1, which forces hazard_reg = 01 in t+1. This kills the wrong-path data fetched in t.
  - Target instruction reaches decode at t+2; penalty is 2 cycles.
  - Clears stall_q.
- Stall at cycle t (no redirect):
  - pc_reg holds; pc_from_IF holds.
  - hazard_ctrl = 10.
  - If hazard_reg (t) = 00: IM_data_buf <= IM_data_in.
  - If hazard_reg (t) = 01: IM_data_buf <= NOP_INSTR.
  - If hazard_reg (t) = 10: IM_data_buf holds.
  - stall_q <= 1.
- Replay: hazard_reg = 10 whenever stall_q = 1 and there is no redirect and no flush_pend.
- Stall release: the first non-stall cycle with stall_q = 1 presents IM_data_buf once more, clears stall_q, and advances pc_reg. The next sequential instruction arrives the following cycle.
- Stall longer than one cycle: the buffer is captured only once, in the first stall cycle.
- Combined select: hazard_reg = 01 if (redirect | flush_pend); else 10 if stall_q; else 00.
- flush_pend clears after one cycle unless redirect is re-asserted.
- Simultaneous stall and redirect: redirect wins; the buffer is not written; stall_q is cleared.

Decomposition:
- Shared package `pipe_pkg`:
  - hazard_reg encodings HZ_NORMAL, HZ_FLUSH, HZ_REPLAY.
  - hazard_ctrl encodings.
  - NOP_INSTR constant.
  - Opcode constants reused by decode.
- One natural sub-module, `if_pc_gen`: PC register, next-PC mux and alignment. The rest (buffer, flush/stall flags, select logic) stays in if_stage.

Test Plan:
- Reset then free run:
  - Release rst; im_addr shows 0, 4, 8, 12 on consecutive cycles.
  - hazard_reg = 01 for the first cycle, then 00.
  - pc_from_IF lags im_addr by exactly 1 cycle.
- Single-cycle stall:
  - With the instruction at PC 0x10 (IM_data_in = 0x00500093) in decode, pulse stall for 1 cycle.
  - Next cycle: hazard_reg = 10, IM_data_buf = 0x00500093, pc_from_IF = 0x10.
  - Then PC 0x14 is decoded with hazard_reg = 00.
- 3-cycle stall:
  - Buffer captured once and unchanged.
  - im_addr constant for 3 cycles.
  - hazard_ctrl = 10 for 3 cycles.
  - No instruction skipped or duplicated after release.
- Redirect to 0x100 while fetching 0x20:
  - hazard_reg = 01 in that cycle and the next.
  - Decode receives the instruction at 0x100 two cycles later, with pc_from_IF = 0x100.
- Redirect to 0x102 asserted together with stall:
  - im_addr = 0x100.
  - IM_data_buf unchanged.
  - No replay (hazard_reg never 10).
- Async reset asserted mid-stream between clock edges:
  - Outputs take reset values immediately.
  - Fetch restarts at RESET_PC after release.
